// File: rtl/act_sched_if.sv
// ============================================================================
// Module   : act_sched_if
// Purpose  : Requester/scheduler signal bundle for the shared ReLU activation
//            unit scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface act_sched_if;
    logic       req0;
    logic [1:0] dst0;
    logic       req1;
    logic [1:0] dst1;
    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic [1:0] sel_i;
    logic       sel_o1;
    logic       sel_o2;
    logic       rtm_en;
    logic       busy;

    modport master (
        output req0, dst0, req1, dst1,
        input  gnt0, gnt1, done0, done1, sel_i, sel_o1, sel_o2, rtm_en, busy
    );

    modport slave (
        input  req0, dst0, req1, dst1,
        output gnt0, gnt1, done0, done1, sel_i, sel_o1, sel_o2, rtm_en, busy
    );
endinterface

`default_nettype wire

// File: rtl/act_sched.sv
// ============================================================================
// Module   : act_sched
// Purpose  : Round-robin scheduler and configuration sequencer for the shared
//            ReLU activation unit (capture, drive, bus-turnaround).
// Revision : 1.0
// ============================================================================
`default_nettype none

module act_sched #(
    parameter int DRIVE_CYC = 1,
    parameter int CNT_W     = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    act_sched_if.slave  bus
);

    localparam logic [1:0]       c_idle     = 2'd0;
    localparam logic [1:0]       c_capture  = 2'd1;
    localparam logic [1:0]       c_drive    = 2'd2;
    localparam logic [1:0]       c_turn     = 2'd3;
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(DRIVE_CYC - 1);

    logic [1:0]       r_state, w_state_nxt;
    logic             r_win, w_win_nxt;
    logic [1:0]       r_dst, w_dst_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic       r_gnt0, r_gnt1, r_done0, r_done1, r_sel_o1, r_sel_o2, r_rtm_en, r_busy;
    logic [1:0] r_sel_i;
    logic       w_gnt0, w_gnt1, w_done0, w_done1, w_sel_o1, w_sel_o2, w_rtm_en, w_busy;
    logic [1:0] w_sel_i;

    // r_win doubles as the round-robin pointer: it only changes when a new
    // winner is chosen, so it always holds the last winner.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= c_idle;
            r_win    <= 1'b1;
            r_dst    <= 2'b00;
            r_cnt    <= '0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_sel_i  <= 2'b00;
            r_sel_o1 <= 1'b0;
            r_sel_o2 <= 1'b0;
            r_rtm_en <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_win    <= w_win_nxt;
            r_dst    <= w_dst_nxt;
            r_cnt    <= w_cnt_nxt;
            r_gnt0   <= w_gnt0;
            r_gnt1   <= w_gnt1;
            r_done0  <= w_done0;
            r_done1  <= w_done1;
            r_sel_i  <= w_sel_i;
            r_sel_o1 <= w_sel_o1;
            r_sel_o2 <= w_sel_o2;
            r_rtm_en <= w_rtm_en;
            r_busy   <= w_busy;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_win_nxt   = r_win;
        w_dst_nxt   = r_dst;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_idle: begin
                if (bus.req0 || bus.req1) begin
                    w_win_nxt   = (bus.req0 && bus.req1) ? ~r_win : bus.req1;
                    w_dst_nxt   = w_win_nxt ? bus.dst1 : bus.dst0;
                    w_state_nxt = c_capture;
                end
            end
            c_capture: begin
                w_cnt_nxt   = c_cnt_load;
                w_state_nxt = (r_dst != 2'b00) ? c_drive : c_turn;
            end
            c_drive: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_turn;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    // Outputs are decoded from the next state and then registered, so each
    // output appears in the same cycle as the state it belongs to.
    always_comb begin
        w_gnt0   = (w_state_nxt == c_capture) && !w_win_nxt;
        w_gnt1   = (w_state_nxt == c_capture) &&  w_win_nxt;
        w_rtm_en = (w_state_nxt == c_capture);
        w_sel_i  = (w_state_nxt == c_capture) ? {1'b1, w_win_nxt} : 2'b00;
        w_sel_o1 = (w_state_nxt == c_drive) && w_dst_nxt[0];
        w_sel_o2 = (w_state_nxt == c_drive) && w_dst_nxt[1];
        w_done0  = (w_state_nxt == c_turn) && !w_win_nxt;
        w_done1  = (w_state_nxt == c_turn) &&  w_win_nxt;
        w_busy   = (w_state_nxt != c_idle);
    end

    assign bus.gnt0   = r_gnt0;
    assign bus.gnt1   = r_gnt1;
    assign bus.done0  = r_done0;
    assign bus.done1  = r_done1;
    assign bus.sel_i  = r_sel_i;
    assign bus.sel_o1 = r_sel_o1;
    assign bus.sel_o2 = r_sel_o2;
    assign bus.rtm_en = r_rtm_en;
    assign bus.busy   = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_act_sched.sv
// ============================================================================
// Module   : tb_act_sched
// Purpose  : Randomized scoreboard bench for act_sched with a transaction-level
//            reference model of arbitration and timing.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_act_sched;

    localparam int N = 2;

    typedef struct {
        int         who;
        logic [1:0] dst;
        int         gnt_cyc;
        int         done_cyc;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    txn_t exp_q[$];
    txn_t cur;
    bit   cur_v = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    act_sched_if bus();

    act_sched #(.DRIVE_CYC(N), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Expected output word {gnt0,gnt1,done0,done1,sel_i,sel_o1,sel_o2,rtm_en,busy}
    function automatic logic [9:0] expect_vec(input bit v, input txn_t t, input int c);
        logic [9:0] e;
        e = '0;
        if (v && c >= t.gnt_cyc && c <= t.done_cyc) begin
            e[0] = 1'b1;
            if (c == t.gnt_cyc) begin
                e[9 - t.who] = 1'b1;
                e[1]         = 1'b1;
                e[5:4]       = (t.who == 1) ? 2'b11 : 2'b10;
            end else if (c == t.done_cyc) begin
                e[7 - t.who] = 1'b1;
            end else begin
                e[3] = t.dst[0];
                e[2] = t.dst[1];
            end
        end
        return e;
    endfunction

    // Monitor: pops a scoreboard entry whenever the DUT presents a grant
    initial begin
        logic [9:0] act;
        logic [9:0] exp_v;
        int         who;
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                exp_q.delete();
                cur_v = 1'b0;
            end else if (bus.gnt0 === 1'b1 || bus.gnt1 === 1'b1) begin
                who = (bus.gnt1 === 1'b1) ? 1 : 0;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL grant: got gnt%0d at cyc %0d, required no grant", who, cyc);
                end else begin
                    cur   = exp_q.pop_front();
                    cur_v = 1'b1;
                    if (cur.who != who || cur.gnt_cyc != cyc) begin
                        fails++;
                        $display("FAIL grant: got gnt%0d at cyc %0d, required gnt%0d at cyc %0d",
                                 who, cyc, cur.who, cur.gnt_cyc);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].gnt_cyc <= cyc) begin
                tests++;
                fails++;
                $display("FAIL grant: got none at cyc %0d, required gnt%0d", cyc, exp_q[0].who);
                cur   = exp_q.pop_front();
                cur_v = 1'b1;
            end
            act   = {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.sel_i,
                     bus.sel_o1, bus.sel_o2, bus.rtm_en, bus.busy};
            exp_v = (rst === 1'b0) ? 10'b0 : expect_vec(cur_v, cur, cyc);
            tests++;
            if (act !== exp_v) begin
                fails++;
                $display("FAIL outputs cyc=%0d got=%b required=%b (gnt0,gnt1,done0,done1,sel_i,o1,o2,rtm,busy)",
                         cyc, act, exp_v);
            end
        end
    end

    // Stimulus and reference model
    initial begin
        int         m_last;
        int         free_at;
        int         m_gnt;
        logic [1:0] m_dst;
        int         g_cyc[2];
        int         rst_left;
        int         w;
        logic [1:0] d;
        bit         contend;
        logic       rq[2];
        logic [1:0] ds[2];

        m_last = 1; free_at = 0; m_gnt = -100; m_dst = 2'b00;
        g_cyc[0] = -1; g_cyc[1] = -1; rst_left = 0;
        rst = 1'b0;
        rq[0] = 1'b1; rq[1] = 1'b1; ds[0] = 2'b10; ds[1] = 2'b11;
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.dst0 = 2'b10; bus.dst1 = 2'b11;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b1;

        for (int it = 0; it < 3000; it++) begin
            contend = (it < 300);
            if (rst == 1'b0) begin
                if (rst_left > 0) begin
                    rst_left--;
                end else begin
                    rst = 1'b1;
                end
            end else if (it > 300 && m_dst != 2'b00 && cyc == m_gnt + 2 && $urandom_range(0, 3) == 0) begin
                // reset during the second drive cycle aborts the transaction
                rst      = 1'b0;
                rst_left = $urandom_range(0, 2);
                m_last   = 1; free_at = 0; m_gnt = -100; m_dst = 2'b00;
                g_cyc[0] = -1; g_cyc[1] = -1;
            end

            for (int r = 0; r < 2; r++) begin
                if (rq[r] && g_cyc[r] == cyc) begin
                    if (!contend && $urandom_range(0, 1) == 0) rq[r] = 1'b0;
                    ds[r] = 2'($urandom_range(0, 3));
                end else if (rq[r]) begin
                    if (!contend && $urandom_range(0, 19) == 0) rq[r] = 1'b0;
                    if ($urandom_range(0, 9) == 0) ds[r] = 2'($urandom_range(0, 3));
                end else if (contend || $urandom_range(0, 2) == 0) begin
                    rq[r] = 1'b1;
                    ds[r] = 2'($urandom_range(0, 3));
                end
            end
            bus.req0 = rq[0]; bus.dst0 = ds[0];
            bus.req1 = rq[1]; bus.dst1 = ds[1];

            if (rst == 1'b1 && cyc >= free_at && (rq[0] || rq[1])) begin
                w = (rq[0] && rq[1]) ? (1 - m_last) : (rq[1] ? 1 : 0);
                d = ds[w];
                exp_q.push_back('{who: w, dst: d, gnt_cyc: cyc + 1,
                                  done_cyc: (d != 2'b00) ? cyc + 2 + N : cyc + 2});
                m_last   = w;
                free_at  = cyc + 3 + ((d != 2'b00) ? N : 0);
                g_cyc[w] = cyc + 1;
                m_gnt    = cyc + 1;
                m_dst    = d;
            end
            @(negedge clk);
            #1;
        end

        rst = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (N + 8) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d outstanding grants, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
